inport_debouncer: RTL and testbench

//   Conditions raw board switches and the "load" pushbutton before they reach the

---
 rtl/inport_debouncer.sv | 122 ++++++++++++
 tb/tb_inport_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/inport_debouncer.sv
// Switch/pushbutton conditioner feeding the datapath input port: 2-flop synchronizers,
// a whole-word switch debouncer and a press-pulse FSM for the load button.
module inport_debouncer #(
    parameter int REG_SIZE        = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [REG_SIZE-1:0] sw_raw,
    input  logic                btn_raw_n,
    output logic [REG_SIZE-1:0] inport_data,
    output logic                data_valid,
    output logic                changed_pulse,
    output logic                btn_pulse
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_t;

    logic [1:0][REG_SIZE-1:0] sw_sync;
    logic [1:0]               btn_sync;
    logic [REG_SIZE-1:0]      sw_s;
    logic                     btn_s;
    logic [REG_SIZE-1:0]      cand;
    logic [CNT_WIDTH-1:0]     sw_cnt;
    logic [CNT_WIDTH-1:0]     btn_cnt;
    btn_state_t               btn_state;

    assign sw_s  = sw_sync[1];
    assign btn_s = btn_sync[1];

    // Button chain resets to 1 so an idle (released) button is seen at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync  <= '0;
            btn_sync <= 2'b11;
        end else begin
            sw_sync  <= {sw_sync[0], sw_raw};
            btn_sync <= {btn_sync[0], btn_raw_n};
        end
    end

    // One counter for the whole word: any bit change restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand          <= '0;
            sw_cnt        <= '0;
            inport_data   <= '0;
            data_valid    <= 1'b0;
            changed_pulse <= 1'b0;
        end else begin
            changed_pulse <= 1'b0;
            if (sw_s != cand) begin
                cand   <= sw_s;
                sw_cnt <= '0;
            end else if (sw_cnt < CNT_MAX) begin
                sw_cnt <= sw_cnt + 1'b1;
            end else begin
                data_valid <= 1'b1;
                if (cand != inport_data) begin
                    inport_data   <= cand;
                    changed_pulse <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_state <= IDLE;
            btn_cnt   <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (btn_state)
                IDLE: begin
                    btn_cnt <= '0;
                    if (!btn_s) btn_state <= DEB_PRESS;
                end
                DEB_PRESS: begin
                    if (btn_s) begin
                        btn_state <= IDLE;
                        btn_cnt   <= '0;
                    end else if (btn_cnt == CNT_MAX) begin
                        btn_state <= PRESSED;
                        btn_cnt   <= '0;
                        btn_pulse <= 1'b1;
                    end else begin
                        btn_cnt <= btn_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    btn_cnt <= '0;
                    if (btn_s) btn_state <= DEB_RELEASE;
                end
                DEB_RELEASE: begin
                    if (!btn_s) begin
                        btn_state <= PRESSED;
                        btn_cnt   <= '0;
                    end else if (btn_cnt == CNT_MAX) begin
                        btn_state <= IDLE;
                        btn_cnt   <= '0;
                    end else begin
                        btn_cnt <= btn_cnt + 1'b1;
                    end
                end
                default: begin
                    btn_state <= IDLE;
                    btn_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inport_debouncer.sv
// Directed bench for inport_debouncer with DEBOUNCE_CYCLES=4: word acceptance latency,
// bounce rejection, button pulse generation and mid-debounce reset.
module tb_inport_debouncer;

    logic        clk;
    logic        reset_n;
    logic [31:0] sw_raw;
    logic        btn_raw_n;
    logic [31:0] inport_data;
    logic        data_valid;
    logic        changed_pulse;
    logic        btn_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int chg_n    = 0;
    int btn_n    = 0;

    inport_debouncer #(
        .REG_SIZE        (32),
        .DEBOUNCE_CYCLES (4),
        .CNT_WIDTH       (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_raw        (sw_raw),
        .btn_raw_n     (btn_raw_n),
        .inport_data   (inport_data),
        .data_valid    (data_valid),
        .changed_pulse (changed_pulse),
        .btn_pulse     (btn_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each registered pulse spans exactly one negedge.
    always @(negedge clk) begin
        if (changed_pulse) chg_n++;
        if (btn_pulse)     btn_n++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        sw_raw    = 32'h0;
        btn_raw_n = 1'b1;
        #12;
        check("rst_inport", inport_data, 32'h0);
        check("rst_valid", {31'b0, data_valid}, 32'h0);
        check("rst_changed", {31'b0, changed_pulse}, 32'h0);
        check("rst_btn", {31'b0, btn_pulse}, 32'h0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chg_n = 0;
        tick(7);
        check("t1_valid", {31'b0, data_valid}, 32'h1);
        check("t1_inport", inport_data, 32'h0);
        check("t1_no_change", chg_n, 0);

        // word change: update on the 7th edge after the change
        sw_raw = 32'h0000_00A5;
        chg_n = 0;
        tick(6);
        check("t2_before", inport_data, 32'h0);
        check("t2_pulse_early", {31'b0, changed_pulse}, 32'h0);
        tick(1);
        check("t2_after", inport_data, 32'hA5);
        check("t2_pulse", {31'b0, changed_pulse}, 32'h1);
        tick(1);
        check("t2_pulse_end", {31'b0, changed_pulse}, 32'h0);
        check("t2_count", chg_n, 1);

        // bounce shorter than the window never propagates
        chg_n = 0;
        for (int i = 0; i < 10; i++) begin
            sw_raw = (i % 2 == 0) ? 32'h5A : 32'hA5;
            tick(2);
        end
        check("t3_hold_old", inport_data, 32'hA5);
        check("t3_no_change", chg_n, 0);
        sw_raw = 32'h5A;
        tick(12);
        check("t3_final", inport_data, 32'h5A);
        check("t3_one_update", chg_n, 1);
        check("t3_valid", {31'b0, data_valid}, 32'h1);

        // press with a 1-cycle glitch, then release
        btn_n = 0;
        btn_raw_n = 1'b0;
        tick(2);
        btn_raw_n = 1'b1;
        tick(1);
        btn_raw_n = 1'b0;
        tick(7);
        btn_raw_n = 1'b1;
        tick(10);
        check("t4_one_pulse", btn_n, 1);
        check("t4_pulse_low", {31'b0, btn_pulse}, 32'h0);

        // too-short press, then a long hold
        btn_n = 0;
        btn_raw_n = 1'b0;
        tick(2);
        btn_raw_n = 1'b1;
        tick(8);
        check("t5_short", btn_n, 0);
        btn_raw_n = 1'b0;
        tick(50);
        check("t5_hold", btn_n, 1);
        btn_raw_n = 1'b1;
        tick(10);
        check("t5_release", btn_n, 1);

        // reset mid-debounce (sw_cnt=2 after the 5th edge)
        sw_raw = 32'hDEAD_BEEF;
        tick(5);
        check("t6_pending", inport_data, 32'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_inport", inport_data, 32'h0);
        check("t6_rst_valid", {31'b0, data_valid}, 32'h0);
        check("t6_rst_changed", {31'b0, changed_pulse}, 32'h0);
        check("t6_rst_btn", {31'b0, btn_pulse}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(6);
        check("t6_before", inport_data, 32'h0);
        check("t6_valid_before", {31'b0, data_valid}, 32'h0);
        tick(1);
        check("t6_after", inport_data, 32'hDEAD_BEEF);
        check("t6_valid_after", {31'b0, data_valid}, 32'h1);
        check("t6_pulse", {31'b0, changed_pulse}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
